decode_stage: RTL and testbench

Registered, flow-controlled RV32I instruction decode stage with optional M-extension decode and illegal-instruction detection. It sits between the fetch stage and the register-read/execute stage. Each instruction is decoded into a compact operation code plus extracted fields, then held in a 2-entry elastic buffer behind valid/ready handshakes on both sides. A flush input discards everything held.

---
 rtl/decode_stage.sv | 224 ++++++++++++++++++++++
 tb/tb_decode_stage.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I (+ optional M) decode stage: decodes the incoming instruction and
// holds results in a 2-entry elastic buffer with valid/ready on both sides.
module decode_stage #(
    parameter bit ENABLE_M = 1'b0,
    parameter int PC_W     = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [5:0]      out_op,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [31:0]     out_imm,
    output logic            out_rd_we,
    output logic            out_rs1_used,
    output logic            out_rs2_used,
    output logic            out_illegal
);
    typedef enum logic [5:0] {
        OP_ILLEGAL = 6'd0, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LOAD, OP_STORE,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        op_e             op;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [31:0]     imm;
        logic            rd_we;
        logic            rs1_used;
        logic            rs2_used;
        logic            illegal;
    } entry_t;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];
    assign imm_i  = {{21{in_instr[31]}}, in_instr[30:20]};
    assign imm_s  = {{21{in_instr[31]}}, in_instr[30:25], in_instr[11:7]};
    assign imm_b  = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u  = {in_instr[31:12], 12'b0};
    assign imm_j  = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    entry_t dec;
    logic   legal;
    logic   writes_rd;

    always_comb begin
        // NOTE: every decode output gets a default here so no branch of the case infers a latch.
        dec        = '0;
        dec.pc     = in_pc;
        dec.rd     = in_instr[11:7];
        dec.rs1    = in_instr[19:15];
        dec.rs2    = in_instr[24:20];
        dec.funct3 = f3;
        legal      = 1'b1;
        writes_rd  = 1'b0;
        case (opcode)
            OPC_LUI:   begin dec.op = OP_LUI;   dec.imm = imm_u; writes_rd = 1'b1; end
            OPC_AUIPC: begin dec.op = OP_AUIPC; dec.imm = imm_u; writes_rd = 1'b1; end
            OPC_JAL:   begin dec.op = OP_JAL;   dec.imm = imm_j; writes_rd = 1'b1; end
            OPC_JALR: begin
                dec.op = OP_JALR; dec.imm = imm_i; writes_rd = 1'b1; dec.rs1_used = 1'b1;
                legal  = (f3 == 3'b000);
            end
            OPC_BRANCH: begin
                dec.imm = imm_b; dec.rs1_used = 1'b1; dec.rs2_used = 1'b1;
                case (f3)
                    3'b000:  dec.op = OP_BEQ;
                    3'b001:  dec.op = OP_BNE;
                    3'b100:  dec.op = OP_BLT;
                    3'b101:  dec.op = OP_BGE;
                    3'b110:  dec.op = OP_BLTU;
                    3'b111:  dec.op = OP_BGEU;
                    default: legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                dec.op = OP_LOAD; dec.imm = imm_i; writes_rd = 1'b1; dec.rs1_used = 1'b1;
                legal  = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
            end
            OPC_STORE: begin
                dec.op = OP_STORE; dec.imm = imm_s; dec.rs1_used = 1'b1; dec.rs2_used = 1'b1;
                legal  = (f3 <= 3'b010);
            end
            OPC_OPIMM: begin
                dec.imm = imm_i; writes_rd = 1'b1; dec.rs1_used = 1'b1;
                case (f3)
                    3'b000: dec.op = OP_ADDI;
                    3'b010: dec.op = OP_SLTI;
                    3'b011: dec.op = OP_SLTIU;
                    3'b100: dec.op = OP_XORI;
                    3'b110: dec.op = OP_ORI;
                    3'b111: dec.op = OP_ANDI;
                    3'b001: begin dec.op = OP_SLLI; legal = (f7 == 7'b0000000); end
                    default: begin
                        dec.op = (f7 == 7'b0100000) ? OP_SRAI : OP_SRLI;
                        legal  = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                    end
                endcase
            end
            OPC_OP: begin
                writes_rd = 1'b1; dec.rs1_used = 1'b1; dec.rs2_used = 1'b1;
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000:  dec.op = OP_ADD;
                        3'b001:  dec.op = OP_SLL;
                        3'b010:  dec.op = OP_SLT;
                        3'b011:  dec.op = OP_SLTU;
                        3'b100:  dec.op = OP_XOR;
                        3'b101:  dec.op = OP_SRL;
                        3'b110:  dec.op = OP_OR;
                        default: dec.op = OP_AND;
                    endcase
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    dec.op = OP_SUB;
                end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                    dec.op = OP_SRA;
                end else if (f7 == 7'b0000001 && ENABLE_M) begin
                    dec.op = op_e'({3'b100, f3});
                end else begin
                    legal = 1'b0;
                end
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec.op       = OP_ILLEGAL;
            dec.imm      = '0;
            dec.illegal  = 1'b1;
            dec.rs1_used = 1'b0;
            dec.rs2_used = 1'b0;
            writes_rd    = 1'b0;
        end
        dec.rd_we = writes_rd && (dec.rd != 5'd0);
    end

    // Two-slot shift buffer: slot0 is always the head and drives out_* directly.
    entry_t     slot0, slot1;
    logic [1:0] count;
    logic       push, pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 2'd0;
            // NOTE: both slots are reset, not just count, so out_* read all-zero out of reset.
            slot0 <= '0;
            slot1 <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            // NOTE: non-blocking so slot0 takes slot1's old value when both update on one edge.
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) slot0 <= dec;
                    else               slot1 <= dec;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        slot0 <= dec;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= dec;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_pc       = slot0.pc;
    assign out_op       = slot0.op;
    assign out_rd       = slot0.rd;
    assign out_rs1      = slot0.rs1;
    assign out_rs2      = slot0.rs2;
    assign out_funct3   = slot0.funct3;
    assign out_imm      = slot0.imm;
    assign out_rd_we    = slot0.rd_we;
    assign out_rs1_used = slot0.rs1_used;
    assign out_rs2_used = slot0.rs2_used;
    assign out_illegal  = slot0.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: ENABLE_M=0 and ENABLE_M=1 instances share stimulus and
// are checked every cycle against a queue-based reference model.
module tb_decode_stage;
    localparam int PC_W = 32;

    typedef struct packed {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
    } item_t;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] imm;
        logic        rd_we;
        logic        rs1_used;
        logic        rs2_used;
        logic        illegal;
    } exp_t;

    localparam int BR_OP  [8] = '{5, 6, 0, 0, 7, 8, 9, 10};
    localparam int OPI_OP [8] = '{13, 19, 14, 15, 16, 20, 17, 18};
    localparam int OP_OP  [8] = '{22, 24, 25, 26, 27, 28, 30, 31};
    localparam logic [6:0] OPCS [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    localparam logic [6:0] F7S  [4] = '{7'h00, 7'h20, 7'h01, 7'h00};

    logic clk = 1'b0;
    logic reset, flush, in_valid, out_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;

    logic            in_ready     [2];
    logic            out_valid    [2];
    logic [PC_W-1:0] out_pc       [2];
    logic [5:0]      out_op       [2];
    logic [4:0]      out_rd       [2];
    logic [4:0]      out_rs1      [2];
    logic [4:0]      out_rs2      [2];
    logic [2:0]      out_funct3   [2];
    logic [31:0]     out_imm      [2];
    logic            out_rd_we    [2];
    logic            out_rs1_used [2];
    logic            out_rs2_used [2];
    logic            out_illegal  [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        decode_stage #(.ENABLE_M(g == 1), .PC_W(PC_W)) dut (
            .clk(clk), .reset(reset), .flush(flush),
            .in_valid(in_valid), .in_ready(in_ready[g]),
            .in_instr(in_instr), .in_pc(in_pc),
            .out_valid(out_valid[g]), .out_ready(out_ready),
            .out_pc(out_pc[g]), .out_op(out_op[g]),
            .out_rd(out_rd[g]), .out_rs1(out_rs1[g]), .out_rs2(out_rs2[g]),
            .out_funct3(out_funct3[g]), .out_imm(out_imm[g]),
            .out_rd_we(out_rd_we[g]), .out_rs1_used(out_rs1_used[g]),
            .out_rs2_used(out_rs2_used[g]), .out_illegal(out_illegal[g])
        );
    end

    int n_vec = 0;
    int n_err = 0;
    int model_pops = 0;
    int dut_pops = 0;
    item_t mq[$];
    bit push_ok;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference decode written straight from the encoding rules.
    function automatic exp_t ref_decode(input logic [31:0] i, input bit en_m);
        exp_t e;
        logic [6:0] opc = i[6:0];
        logic [2:0] f3 = i[14:12];
        logic [6:0] f7 = i[31:25];
        int op = 0;
        bit rdw = 0, r1 = 0, r2 = 0;
        logic [31:0] imm = 32'd0;
        case (opc)
            7'h37: begin op = 1; imm = {i[31:12], 12'b0}; rdw = 1; end
            7'h17: begin op = 2; imm = {i[31:12], 12'b0}; rdw = 1; end
            7'h6F: begin op = 3; imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); rdw = 1; end
            7'h67: begin op = (f3 == 0) ? 4 : 0; imm = 32'($signed(i[31:20])); rdw = 1; r1 = 1; end
            7'h63: begin op = BR_OP[f3]; imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); r1 = 1; r2 = 1; end
            7'h03: begin op = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ? 11 : 0; imm = 32'($signed(i[31:20])); rdw = 1; r1 = 1; end
            7'h23: begin op = (f3 <= 2) ? 12 : 0; imm = 32'($signed({i[31:25], i[11:7]})); r1 = 1; r2 = 1; end
            7'h13: begin
                op = OPI_OP[f3]; imm = 32'($signed(i[31:20])); rdw = 1; r1 = 1;
                if (f3 == 1 && f7 != 0) op = 0;
                if (f3 == 5) op = (f7 == 0) ? 20 : (f7 == 7'h20) ? 21 : 0;
            end
            7'h33: begin
                rdw = 1; r1 = 1; r2 = 1;
                if (f7 == 0)                     op = OP_OP[f3];
                else if (f7 == 7'h20 && f3 == 0) op = 23;
                else if (f7 == 7'h20 && f3 == 5) op = 29;
                else if (f7 == 7'h01 && en_m)    op = 32 + int'(f3);
            end
            default: op = 0;
        endcase
        e.op       = 6'(op);
        e.illegal  = (op == 0);
        e.imm      = imm;
        e.rd_we    = (op != 0) && rdw && (i[11:7] != 0);
        e.rs1_used = (op != 0) && r1;
        e.rs2_used = (op != 0) && r2;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] i = $urandom();
        if ($urandom_range(0, 3) != 0) i[6:0] = OPCS[$urandom_range(0, 8)];
        if ($urandom_range(0, 1) == 1) i[31:25] = F7S[$urandom_range(0, 3)];
        return i;
    endfunction

    // Model update on the same edge the DUT samples.
    always @(posedge clk) begin
        if (reset || flush) begin
            mq.delete();
        end else begin
            push_ok = in_valid && (mq.size() < 2);
            if (out_ready && mq.size() > 0) begin
                void'(mq.pop_front());
                model_pops++;
            end
            if (push_ok) mq.push_back('{instr: in_instr, pc: in_pc});
        end
    end

    task automatic compare_all();
        exp_t e;
        for (int g = 0; g < 2; g++) begin
            check($sformatf("out_valid[%0d]", g), 64'(out_valid[g]), 64'(mq.size() > 0));
            check($sformatf("in_ready[%0d]", g), 64'(in_ready[g]), 64'(mq.size() < 2));
            if (mq.size() > 0) begin
                e = ref_decode(mq[0].instr, g == 1);
                check($sformatf("pc[%0d]", g), 64'(out_pc[g]), 64'(mq[0].pc));
                check($sformatf("op[%0d]", g), 64'(out_op[g]), 64'(e.op));
                check($sformatf("rd[%0d]", g), 64'(out_rd[g]), 64'(mq[0].instr[11:7]));
                check($sformatf("rs1[%0d]", g), 64'(out_rs1[g]), 64'(mq[0].instr[19:15]));
                check($sformatf("rs2[%0d]", g), 64'(out_rs2[g]), 64'(mq[0].instr[24:20]));
                check($sformatf("funct3[%0d]", g), 64'(out_funct3[g]), 64'(mq[0].instr[14:12]));
                check($sformatf("rd_we[%0d]", g), 64'(out_rd_we[g]), 64'(e.rd_we));
                check($sformatf("rs1_used[%0d]", g), 64'(out_rs1_used[g]), 64'(e.rs1_used));
                check($sformatf("rs2_used[%0d]", g), 64'(out_rs2_used[g]), 64'(e.rs2_used));
                check($sformatf("illegal[%0d]", g), 64'(out_illegal[g]), 64'(e.illegal));
                if (!e.illegal) check($sformatf("imm[%0d]", g), 64'(out_imm[g]), 64'(e.imm));
            end
        end
    endtask

    // Advance one clock; inputs are driven and outputs compared at the negedge.
    task automatic cycle();
        if (out_valid[0] && out_ready && !flush && !reset) dut_pops++;
        @(negedge clk);
        compare_all();
    endtask

    task automatic send_one(input logic [31:0] instr, input logic [PC_W-1:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic expect_head(input int g, input string tag, input logic [5:0] op, input logic [31:0] imm,
                               input bit rd_we, input bit r1u, input bit r2u, input bit ill);
        check({tag, "_valid"}, 64'(out_valid[g]), 64'd1);
        check({tag, "_op"}, 64'(out_op[g]), 64'(op));
        check({tag, "_rd_we"}, 64'(out_rd_we[g]), 64'(rd_we));
        check({tag, "_rs1_used"}, 64'(out_rs1_used[g]), 64'(r1u));
        check({tag, "_rs2_used"}, 64'(out_rs2_used[g]), 64'(r2u));
        check({tag, "_illegal"}, 64'(out_illegal[g]), 64'(ill));
        if (!ill) check({tag, "_imm"}, 64'(out_imm[g]), 64'(imm));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PC_W-1:0] pc;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = 32'd0; in_pc = '0;
        cycle();
        cycle();
        reset = 1'b0;
        for (int g = 0; g < 2; g++) begin
            check("rst_out_valid", 64'(out_valid[g]), 64'd0);
            check("rst_in_ready", 64'(in_ready[g]), 64'd1);
            check("rst_op", 64'(out_op[g]), 64'd0);
            check("rst_illegal", 64'(out_illegal[g]), 64'd0);
            check("rst_imm", 64'(out_imm[g]), 64'd0);
            check("rst_pc", 64'(out_pc[g]), 64'd0);
            check("rst_rd_we", 64'(out_rd_we[g]), 64'd0);
        end

        // Model pins independent of the DUT.
        check("model_sub", 64'(ref_decode(32'h40208033, 1'b0).op), 64'd23);
        check("model_srai", 64'(ref_decode(32'h4010D093, 1'b0).op), 64'd21);

        send_one(32'hFFF00093, 32'h100);
        expect_head(0, "addi", 6'd13, 32'hFFFFFFFF, 1, 1, 0, 0);
        check("addi_rd", 64'(out_rd[0]), 64'd1);
        check("addi_rs1", 64'(out_rs1[0]), 64'd0);

        send_one(32'h022081B3, 32'h104);
        expect_head(0, "mul_m0", 6'd0, 32'd0, 0, 0, 0, 1);
        expect_head(1, "mul_m1", 6'd32, 32'd0, 1, 1, 1, 0);

        send_one(32'h00000000, 32'h108);
        expect_head(0, "zero_m0", 6'd0, 32'd0, 0, 0, 0, 1);
        expect_head(1, "zero_m1", 6'd0, 32'd0, 0, 0, 0, 1);

        send_one(32'hFE000EE3, 32'h10C);
        expect_head(0, "beq", 6'd5, 32'hFFFFFFFC, 0, 1, 1, 0);
        send_one(32'h0080006F, 32'h110);
        expect_head(0, "jal", 6'd3, 32'd8, 0, 0, 0, 0);
        send_one(32'h00112423, 32'h114);
        expect_head(0, "sw", 6'd12, 32'd8, 0, 1, 1, 0);
        send_one(32'h123450B7, 32'h118);
        expect_head(0, "lui", 6'd1, 32'h12345000, 1, 0, 0, 0);
        cycle();

        // Backpressure: A, B accepted, C held until room frees up.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h002081B3; in_pc = 32'h200;
        cycle();
        check("bp_ready_after_a", 64'(in_ready[0]), 64'd1);
        in_instr = 32'h00308233; in_pc = 32'h204;
        cycle();
        check("bp_ready_full", 64'(in_ready[0]), 64'd0);
        in_instr = 32'h004182B3; in_pc = 32'h208;
        cycle();
        check("bp_hold_ready", 64'(in_ready[0]), 64'd0);
        check("bp_head_a", 64'(out_pc[0]), 64'h200);
        out_ready = 1'b1;
        cycle();
        check("bp_head_b", 64'(out_pc[0]), 64'h204);
        check("bp_ready_back", 64'(in_ready[0]), 64'd1);
        cycle();
        check("bp_head_c", 64'(out_pc[0]), 64'h208);
        in_valid = 1'b0;
        cycle();
        check("bp_drained", 64'(out_valid[0]), 64'd0);

        // Flush with a full buffer and a concurrent input.
        out_ready = 1'b0;
        send_one(32'h00100093, 32'h300);
        send_one(32'h00200093, 32'h304);
        in_valid = 1'b1; flush = 1'b1; in_instr = 32'h00300093; in_pc = 32'h308;
        cycle();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("flush_valid", 64'(out_valid[0]), 64'd0);
        check("flush_ready", 64'(in_ready[0]), 64'd1);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("flush_no_emit", 64'(out_valid[0]), 64'd0);
        end

        // Randomized traffic.
        pc = 32'h1000;
        for (int n = 0; n < 3000; n++) begin
            reset     = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 29) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            in_instr  = rand_instr();
            in_pc     = pc;
            pc        = pc + 32'd4;
            cycle();
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) cycle();
        check("pop_count", 64'(dut_pops), 64'(model_pops));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
